bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 14 +
 rtl/bus_if.sv | 12 +
 rtl/bus_arbiter_rr_pick.sv | 38 +++
 rtl/bus_arbiter.sv | 139 +++++++++++++
 tb/tb_bus_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types for the bus arbiter: FSM state encoding and a wrap-around index helper.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_if.sv
// Shared slave bus: two-beat transactions, each beat handshaken by valid/ready.
interface bus_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              read;
    logic              ready;
    logic [DATA_W-1:0] read_data;

    modport master (output valid, output read, input ready, input read_data);
    modport slave  (input valid, input read, output ready, output read_data);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        win     = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int off = 0; off < N; off++) begin
            pos = int'(ptr) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDX_W'(pos);
            if (!any && req[pos_idx]) begin
                any          = 1'b1;
                idx          = pos_idx;
                win[pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one master at a time onto a shared two-beat bus.
// Optional watchdog abort is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_valid,
    input  logic [NUM_MASTERS-1:0] m_read,
    output logic [NUM_MASTERS-1:0] m_ready,
    output logic [DATA_W-1:0]      m_rdata,
    output logic [NUM_MASTERS-1:0] m_grant,
    output logic [NUM_MASTERS-1:0] m_err,
    bus_if.master                  busm
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    state_t                 state, state_next;
    logic [NUM_MASTERS-1:0] grant, grant_next;
    logic [IDX_W-1:0]       grant_idx, grant_idx_next;
    logic [IDX_W-1:0]       ptr, ptr_next;
    logic [NUM_MASTERS-1:0] pick_win;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   held;
    logic                   bus_valid;
    logic                   beat_done;
    logic                   timeout;

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (m_valid),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The bus is driven straight from the granted master; nothing leaks out while IDLE.
    assign held      = (state != IDLE);
    assign bus_valid = held & m_valid[grant_idx];
    assign beat_done = bus_valid & busm.ready;

    assign busm.valid = bus_valid;
    assign busm.read  = held & m_read[grant_idx];
    assign m_ready    = held ? (grant & {NUM_MASTERS{busm.ready}}) : '0;
    assign m_rdata    = held ? busm.read_data : '0;
    assign m_grant    = grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            ptr       <= '0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            grant_idx <= grant_idx_next;
            ptr       <= ptr_next;
        end
    end

    // Grant is latched on leaving IDLE and held until the data beat (or an abort) retires it.
    always_comb begin
        state_next     = state;
        grant_next     = grant;
        grant_idx_next = grant_idx;
        ptr_next       = ptr;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next     = ADDR;
                    grant_next     = pick_win;
                    grant_idx_next = pick_idx;
                end
            end
            ADDR: begin
                if (timeout) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = IDX_W'(wrap_inc(int'(grant_idx), NUM_MASTERS));
                end else if (beat_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (timeout || beat_done) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = IDX_W'(wrap_inc(int'(grant_idx), NUM_MASTERS));
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]       timer;
    logic [NUM_MASTERS-1:0] err;

    // Counts stalled beat cycles; restarts whenever the state changes or a beat lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
            err   <= '0;
        end else begin
            if (!held || beat_done || (state_next != state)) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            err <= timeout ? grant : '0;
        end
    end

    assign timeout = held && !beat_done && (timer == CNT_W'(TIMEOUT_CYCLES - 1));
    assign m_err   = err;
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT_CYCLES > 0);
    assign timeout        = 1'b0;
    assign m_err          = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter plus hand-written stall and timeout sequences.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  m_valid = '0;
    logic [3:0]  m_read = '0;
    logic [3:0]  m_ready;
    logic [31:0] m_rdata;
    logic [3:0]  m_grant;
    logic [3:0]  m_err;

    int tests = 0;
    int failures = 0;

    bus_if #(.DATA_W(32)) bus ();

    bus_arbiter #(
        .NUM_MASTERS    (4),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_valid (m_valid),
        .m_read  (m_read),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .m_grant (m_grant),
        .m_err   (m_err),
        .busm    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  read;
        logic        sready;
        logic [31:0] rdata;
        logic [3:0]  e_grant;
        logic [3:0]  e_ready;
        logic [31:0] e_rdata;
        logic        e_bvalid;
        logic        e_bread;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] read,
                                input logic sready, input logic [31:0] rdata,
                                input logic [3:0] e_grant, input logic [3:0] e_ready,
                                input logic [31:0] e_rdata, input logic e_bvalid, input logic e_bread);
        vec_t v;
        v.rst = rst; v.valid = valid; v.read = read; v.sready = sready; v.rdata = rdata;
        v.e_grant = e_grant; v.e_ready = e_ready; v.e_rdata = e_rdata;
        v.e_bvalid = e_bvalid; v.e_bread = e_bread;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        reset         = v.rst;
        m_valid       = v.valid;
        m_read        = v.read;
        bus.ready     = v.sready;
        bus.read_data = v.rdata;
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.ready     = 1'b0;
        bus.read_data = '0;

        // Reset held with every master requesting
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
        // All four requesting, slave always ready: 0001,0010,0100,1000,0001
        for (int k = 0; k < 5; k++) begin
            logic [3:0] g;
            g = 4'b0001 << (k % 4);
            vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
            vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, g, g, 0, 1, 0));
            vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, g, g, 0, 1, 0));
        end
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
        // Master 2 read returning slave data
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 32'hDEACBEFF, 4'b0000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 32'hDEACBEFF, 4'b0100, 4'b0100, 32'hDEACBEFF, 1, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 32'hDEACBEFF, 4'b0100, 4'b0100, 32'hDEACBEFF, 1, 1));
        // Master 1 granted, master 3 joins mid-transaction and must wait
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1010, 4'b0000, 1, 0, 4'b0010, 4'b0010, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1010, 4'b0000, 1, 0, 4'b0010, 4'b0010, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1010, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 4'b1000, 4'b1000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 4'b1000, 4'b1000, 0, 1, 0));
        // Master 0 drops valid for 3 ADDR cycles while master 3 requests
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(0, 4'b1000, 4'b0000, 1, 0, 4'b0001, 4'b0001, 0, 0, 0));
        end
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 1, 0, 4'b0001, 4'b0001, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 1, 0, 4'b0001, 4'b0001, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
        // Single persistent requester re-granted, then reset mid-transaction
        for (int k = 0; k < 2; k++) begin
            vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
            vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 0, 4'b0001, 4'b0001, 0, 1, 0));
            if (k == 0) begin
                vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 0, 4'b0001, 4'b0001, 0, 1, 0));
            end
        end
        vecs.push_back(mk(1, 4'b1001, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 1, 0, 4'b0001, 4'b0001, 0, 1, 0));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("v%0d grant", i), 32'(m_grant), 32'(vecs[i].e_grant));
            check_output($sformatf("v%0d ready", i), 32'(m_ready), 32'(vecs[i].e_ready));
            check_output($sformatf("v%0d rdata", i), m_rdata, vecs[i].e_rdata);
            check_output($sformatf("v%0d bus_valid", i), 32'(bus.valid), 32'(vecs[i].e_bvalid));
            check_output($sformatf("v%0d bus_read", i), 32'(bus.read), 32'(vecs[i].e_bread));
            check_output($sformatf("v%0d err", i), 32'(m_err), 32'h0);
        end

        // Slave never ready: grant to master 0 with a bounded wait
        @(negedge clk);
        reset     = 1'b1;
        m_valid   = 4'b0001;
        m_read    = 4'b0000;
        bus.ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        begin
            int budget;
            budget = 0;
            next_sample();
            while (m_grant == 4'b0000 && budget < 4) begin
                next_sample();
                budget++;
            end
            check_output("stall grant", 32'(m_grant), 32'h1);
        end
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            next_sample();
            check_output($sformatf("timeout hold %0d grant", k), 32'(m_grant), 32'h1);
            check_output($sformatf("timeout hold %0d err", k), 32'(m_err), 32'h0);
        end
        next_sample();
        check_output("timeout pulse err", 32'(m_err), 32'h1);
        check_output("timeout pulse grant", 32'(m_grant), 32'h0);
        next_sample();
        check_output("timeout after err", 32'(m_err), 32'h0);
`else
        for (int k = 0; k < 20; k++) begin
            next_sample();
            check_output($sformatf("stall %0d grant", k), 32'(m_grant), 32'h1);
            check_output($sformatf("stall %0d err", k), 32'(m_err), 32'h0);
            check_output($sformatf("stall %0d ready", k), 32'(m_ready), 32'h0);
        end
        bus.ready = 1'b1;
        #1;
        check_output("release addr ready", 32'(m_ready), 32'h1);
        next_sample();
        check_output("release data grant", 32'(m_grant), 32'h1);
        check_output("release data valid", 32'(bus.valid), 32'h1);
        next_sample();
        check_output("release idle grant", 32'(m_grant), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
